md_ctrl: RTL and testbench

//  Sequencer for the multi-cycle multiply/divide resource next to the EX stage; owns HI/LO.

---
 rtl/md_pkg.sv | 28 ++
 rtl/md_arith.sv | 56 +++++
 rtl/md_ctrl.sv | 114 +++++++++++
 tb/tb_md_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared encodings, widths and helpers for the multiply/divide sequencer.
// Default cycle counts size the counter when the block is used with stock parameters.
package md_pkg;

    localparam int MD_OP_W = 3;

    localparam logic [MD_OP_W-1:0] MD_MULT  = 3'd0;
    localparam logic [MD_OP_W-1:0] MD_MULTU = 3'd1;
    localparam logic [MD_OP_W-1:0] MD_DIV   = 3'd2;
    localparam logic [MD_OP_W-1:0] MD_DIVU  = 3'd3;
    localparam logic [MD_OP_W-1:0] MD_MTHI  = 3'd4;
    localparam logic [MD_OP_W-1:0] MD_MTLO  = 3'd5;

    localparam int MD_MULT_CYCLES_DEF = 5;
    localparam int MD_DIV_CYCLES_DEF  = 10;
    localparam int MD_CNT_W           = $clog2(MD_DIV_CYCLES_DEF + 1);

    typedef enum logic {MD_IDLE, MD_RUN} md_state_e;

    function automatic logic md_is_arith(input logic [MD_OP_W-1:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic md_is_div(input logic [MD_OP_W-1:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational 32x32 multiply / divide producing the 64-bit {hi,lo} result.
// One multiplier and one divider are shared between the signed and unsigned forms.
module md_arith
    import md_pkg::*;
(
    input  logic [MD_OP_W-1:0] op,
    input  logic [31:0]        rs_data,
    input  logic [31:0]        rt_data,
    output logic [31:0]        res_hi,
    output logic [31:0]        res_lo,
    output logic               div0
);

    logic               is_signed;
    logic signed [32:0] mul_a;
    logic signed [32:0] mul_b;
    logic signed [63:0] prod;
    logic [31:0]        mag_rs;
    logic [31:0]        mag_rt;
    logic [31:0]        quo_m;
    logic [31:0]        rem_m;
    logic [31:0]        quo;
    logic [31:0]        rem;

    always_comb begin
        is_signed = (op == MD_MULT) || (op == MD_DIV);
        div0      = md_is_div(op) && (rt_data == 32'd0);

        // A 33-bit signed operand covers both the signed and unsigned 32-bit ranges.
        mul_a = $signed({is_signed & rs_data[31], rs_data});
        mul_b = $signed({is_signed & rt_data[31], rt_data});
        prod  = 64'(mul_a) * 64'(mul_b);

        // Divide on magnitudes so INT_MIN / -1 wraps to INT_MIN instead of trapping.
        mag_rs = (is_signed && rs_data[31]) ? -rs_data : rs_data;
        mag_rt = (is_signed && rt_data[31]) ? -rt_data : rt_data;
        if (mag_rt == 32'd0) begin
            mag_rt = 32'd1;
        end
        quo_m = mag_rs / mag_rt;
        rem_m = mag_rs % mag_rt;
        quo   = (is_signed && (rs_data[31] ^ rt_data[31])) ? -quo_m : quo_m;
        rem   = (is_signed && rs_data[31]) ? -rem_m : rem_m;

        res_hi = 32'd0;
        res_lo = 32'd0;
        if (md_is_div(op)) begin
            res_hi = rem;
            res_lo = quo;
        end else if (md_is_arith(op)) begin
            res_hi = prod[63:32];
            res_lo = prod[31:0];
        end
    end

endmodule

// File: rtl/md_ctrl.sv
// Multiply/divide sequencer: latches one MD op, counts its latency, commits HI/LO,
// and stalls ID while an MD-using instruction waits for the unit.
module md_ctrl
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [MD_OP_W-1:0] op,
    input  logic [31:0]        rs_data,
    input  logic [31:0]        rt_data,
    input  logic               md_use_ID,
    output logic               busy,
    output logic               stall_md,
    output logic [31:0]        hi,
    output logic [31:0]        lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    md_state_e          state;
    md_state_e          state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               accept;
    logic               commit;
    logic [MD_OP_W-1:0] op_q;
    logic [31:0]        rs_q;
    logic [31:0]        rt_q;
    logic [31:0]        res_hi;
    logic [31:0]        res_lo;
    logic               div0;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        commit    = 1'b0;
        case (state)
            MD_IDLE: begin
                if (start && md_is_arith(op)) begin
                    state_nxt = MD_RUN;
                    accept    = 1'b1;
                    cnt_nxt   = md_is_div(op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                end
            end
            MD_RUN: begin
                if (cnt == CNT_W'(1)) begin
                    state_nxt = MD_IDLE;
                    commit    = 1'b1;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: state_nxt = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= MD_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Operands stay frozen for the whole run, so the combinational result is stable at commit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q <= MD_MULT;
            rs_q <= '0;
            rt_q <= '0;
        end else if (accept) begin
            op_q <= op;
            rs_q <= rs_data;
            rt_q <= rt_data;
        end
    end

    md_arith u_arith (
        .op      (op_q),
        .rs_data (rs_q),
        .rt_data (rt_q),
        .res_hi  (res_hi),
        .res_lo  (res_lo),
        .div0    (div0)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else if (commit) begin
            if (!div0) begin
                hi <= res_hi;
                lo <= res_lo;
            end
        end else if (state == MD_IDLE && start) begin
            if (op == MD_MTHI) hi <= rs_data;
            if (op == MD_MTLO) lo <= rs_data;
        end
    end

    assign busy     = (state == MD_RUN);
    assign stall_md = md_use_ID & (busy | (start & md_is_arith(op)));

endmodule

// File: tb/tb_md_ctrl.sv
// Directed bench for md_ctrl: table of MD ops with hand-computed HI/LO and latency,
// followed by hand-written stall, ignored-start and mid-operation reset sequences.
module tb_md_ctrl;
    import md_pkg::*;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic [MD_OP_W-1:0] op;
    logic [31:0]        rs_data;
    logic [31:0]        rt_data;
    logic               md_use_ID;
    logic               busy;
    logic               stall_md;
    logic [31:0]        hi;
    logic [31:0]        lo;

    int errors = 0;
    int checks = 0;

    md_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .rs_data   (rs_data),
        .rt_data   (rt_data),
        .md_use_ID (md_use_ID),
        .busy      (busy),
        .stall_md  (stall_md),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          exp_cyc;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one op for a single edge, then count busy cycles until the unit idles.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int cyc);
        start   = 1'b1;
        op      = o;
        rs_data = a;
        rt_data = b;
        step();
        start = 1'b0;
        cyc   = 0;
        while (busy && cyc < 100) begin
            cyc++;
            step();
        end
    endtask

    initial begin
        int cyc;

        vecs[0]  = '{"mult_neg",    MD_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 5};
        vecs[1]  = '{"divu_100_7",  MD_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       10};
        vecs[2]  = '{"div_m7_2",    MD_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[3]  = '{"multu_max",   MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
        vecs[4]  = '{"div_ovf",     MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
        vecs[5]  = '{"mult_minmin", MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};
        vecs[6]  = '{"div_7_m2",    MD_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
        vecs[7]  = '{"mthi",        MD_MTHI,  32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFD, 0};
        vecs[8]  = '{"mtlo",        MD_MTLO,  32'h00005678, 32'd0,        32'h00001234, 32'h00005678, 0};
        vecs[9]  = '{"div_by0",     MD_DIV,   32'd5,        32'd0,        32'h00001234, 32'h00005678, 10};
        vecs[10] = '{"multu_2p32",  MD_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 5};

        reset     = 1'b1;
        start     = 1'b0;
        op        = MD_MULT;
        rs_data   = '0;
        rt_data   = '0;
        md_use_ID = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_hi",   64'(hi),   64'd0);
        chk("rst_lo",   64'(lo),   64'd0);
        md_use_ID = 1'b1;
        #1;
        chk("rst_stall_use", 64'(stall_md), 64'd0);
        md_use_ID = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        step();

        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i].op, vecs[i].rs, vecs[i].rt, cyc);
            chk({vecs[i].name, "_cyc"}, 64'(cyc), 64'(vecs[i].exp_cyc));
            chk({vecs[i].name, "_hi"},  64'(hi),  64'(vecs[i].exp_hi));
            chk({vecs[i].name, "_lo"},  64'(lo),  64'(vecs[i].exp_lo));
        end

        // MFLO waiting in ID while a MULT runs: stall from the start cycle until commit.
        md_use_ID = 1'b1;
        start     = 1'b1;
        op        = MD_MULT;
        rs_data   = 32'd3;
        rt_data   = 32'd5;
        #1;
        chk("stall_start", 64'(stall_md), 64'd1);
        step();
        start = 1'b0;
        cyc   = 0;
        while (busy && cyc < 100) begin
            cyc++;
            checks++;
            if (stall_md !== 1'b1) begin
                errors++;
                $display("FAIL stall_busy: cycle %0d got %b expected 1", cyc, stall_md);
            end
            step();
        end
        chk("stall_cyc",     64'(cyc),      64'd5);
        chk("stall_release", 64'(stall_md), 64'd0);
        chk("stall_lo",      64'(lo),       64'd15);
        chk("stall_hi",      64'(hi),       64'd0);

        // A non-arith MD op never stalls ID.
        start   = 1'b1;
        op      = MD_MTHI;
        rs_data = 32'h0000ABCD;
        #1;
        chk("mthi_nostall", 64'(stall_md), 64'd0);
        step();
        start     = 1'b0;
        md_use_ID = 1'b0;
        chk("mthi_hi", 64'(hi), 64'h0000ABCD);
        chk("mthi_lo", 64'(lo), 64'd15);

        // Second start during RUN must not disturb count or result.
        start   = 1'b1;
        op      = MD_MULTU;
        rs_data = 32'hFFFFFFFF;
        rt_data = 32'hFFFFFFFF;
        step();
        start = 1'b0;
        cyc   = 0;
        while (busy && cyc < 100) begin
            cyc++;
            if (cyc == 2) begin
                start   = 1'b1;
                op      = MD_DIVU;
                rs_data = 32'd100;
                rt_data = 32'd7;
            end else begin
                start = 1'b0;
            end
            step();
        end
        start = 1'b0;
        chk("ign_cyc", 64'(cyc), 64'd5);
        chk("ign_hi",  64'(hi),  64'hFFFFFFFE);
        chk("ign_lo",  64'(lo),  64'h00000001);
        step();
        chk("ign_idle", 64'(busy), 64'd0);

        // Reset in the fourth busy cycle of a DIV abandons it.
        run_op_start: begin
            start   = 1'b1;
            op      = MD_DIV;
            rs_data = 32'd100;
            rt_data = 32'd7;
            step();
            start = 1'b0;
        end
        repeat (3) step();
        chk("mid_busy_before", 64'(busy), 64'd1);
        #2;
        reset     = 1'b1;
        md_use_ID = 1'b1;
        #1;
        chk("mid_busy",  64'(busy),     64'd0);
        chk("mid_hi",    64'(hi),       64'd0);
        chk("mid_lo",    64'(lo),       64'd0);
        chk("mid_stall", 64'(stall_md), 64'd0);
        @(negedge clk);
        reset     = 1'b0;
        md_use_ID = 1'b0;
        repeat (15) step();
        chk("post_busy", 64'(busy), 64'd0);
        chk("post_hi",   64'(hi),   64'd0);
        chk("post_lo",   64'(lo),   64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
